// File: rtl/pattern_transmitter.sv
// pattern_transmitter
//   Serial source for the pattern detection path. A pattern captured while
//   idle is shifted out LSB first, one bit per clock, so a detector that
//   shifts serial_out into its MSB holds the pattern after the last bit.
//   A start sends repeat_cnt+1 frames, optionally separated by GAP idle
//   cycles, and finishes with a one-cycle done pulse. abort returns to idle
//   at once without a done pulse.
//
//   Optional feature: define PATTERN_TX_PARITY_EN to append an even-parity
//   bit (XOR of the pattern bits) to every frame.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   load         capture pattern into the pattern register (idle only)
//   pattern      pattern to capture
//   start        begin transmission (idle only)
//   repeat_cnt   frames to send minus one, sampled with start
//   abort        terminate transmission and return to idle
//   serial_out   registered serial data, IDLE_LVL when not transmitting
//   serial_valid high in every cycle serial_out carries a frame bit
//   busy         high while a transmission is in progress
//   done         one-cycle pulse after the final bit of the final frame

module pattern_transmitter #(
  parameter int   WIDTH    = 5,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 0,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

`ifdef PATTERN_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam int PAD   = 1 << BIT_W;
  localparam int GAP_W = $clog2(GAP + 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pat_reg, pat_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             out_nxt;
  logic             valid_nxt;
  logic             done_nxt;

  // Bit idx of a frame. The pattern is zero-extended to a power of two so
  // the index width always matches; the parity slot sits just past the
  // pattern bits when that feature is built in.
  function automatic logic frame_bit(input logic [WIDTH-1:0] pat,
                                     input logic [BIT_W-1:0] idx);
    logic [PAD-1:0] ext;
    ext = PAD'(pat);
`ifdef PATTERN_TX_PARITY_EN
    if (idx == BIT_W'(WIDTH)) return ^pat;
`endif
    return ext[idx];
  endfunction

  // Next-state and next-output logic. Outputs are registered together with
  // the state, so whatever is computed here for the next state is exactly
  // what appears on the pins in that state: SHIFT with bit_cnt b is the
  // cycle in which bit b is on serial_out.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_reg;
    bit_nxt   = bit_cnt;
    frame_nxt = frame_cnt;
    gap_nxt   = gap_cnt;
    out_nxt   = IDLE_LVL;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) pat_nxt = pattern;
        // abort wins over start; with load+start the fresh pattern goes out
        if (start && !abort) begin
          state_nxt = SHIFT;
          frame_nxt = repeat_cnt;
          bit_nxt   = '0;
          gap_nxt   = '0;
          out_nxt   = pat_nxt[0];
          valid_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          bit_nxt   = '0;
          frame_nxt = '0;
          gap_nxt   = '0;
        end else if (bit_cnt != LAST_BIT) begin
          bit_nxt   = bit_cnt + BIT_W'(1);
          out_nxt   = frame_bit(pat_reg, bit_nxt);
          valid_nxt = 1'b1;
        end else begin
          bit_nxt = '0;
          if (frame_cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            // the frame counter only counts down to zero, so an all-ones
            // repeat_cnt yields 2^CNT_W frames without wrapping
            frame_nxt = frame_cnt - CNT_W'(1);
            if (GAP > 0) begin
              state_nxt = GAP_WAIT;
              gap_nxt   = GAP_W'(GAP - 1);
            end else begin
              out_nxt   = frame_bit(pat_reg, '0);
              valid_nxt = 1'b1;
            end
          end
        end
      end
      GAP_WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
          bit_nxt   = '0;
          frame_nxt = '0;
          gap_nxt   = '0;
        end else if (gap_cnt == '0) begin
          state_nxt = SHIFT;
          bit_nxt   = '0;
          out_nxt   = frame_bit(pat_reg, '0);
          valid_nxt = 1'b1;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, pattern and all outputs are registered here; reset
  // overrides everything, including a frame in flight, and never pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pat_reg      <= '0;
      bit_cnt      <= '0;
      frame_cnt    <= '0;
      gap_cnt      <= '0;
      serial_out   <= IDLE_LVL;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      pat_reg      <= pat_nxt;
      bit_cnt      <= bit_nxt;
      frame_cnt    <= frame_nxt;
      gap_cnt      <= gap_nxt;
      serial_out   <= out_nxt;
      serial_valid <= valid_nxt;
      busy         <= (state_nxt != IDLE);
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_transmitter.sv
// tb_pattern_transmitter
//   Drives two transmitters (GAP=0 and GAP=2) from the same inputs and
//   compares every output on every cycle against a frame-level model that
//   expands each accepted start into the full expected waveform.

module tb_pattern_transmitter;

  localparam int   WIDTH    = 5;
  localparam int   CNT_W    = 4;
  localparam logic IDLE_LVL = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  typedef struct packed {
    logic valid;
    logic bitv;
    logic busy;
    logic done;
  } rec_t;
  typedef rec_t rec_q_t[$];

  localparam rec_t IDLE_REC = '{1'b0, IDLE_LVL, 1'b0, 1'b0};

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             so0, sv0, busy0, done0;
  logic             so2, sv2, busy2, done2;

  int num_checks = 0;
  int num_fail   = 0;
  int cyc        = 0;

  rec_t             cur0, cur2;
  rec_q_t           q0, q2;
  logic [WIDTH-1:0] mpat0, mpat2;
  logic [FL-1:0]    det0, det2;

  pattern_transmitter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0), .IDLE_LVL(IDLE_LVL)) dut0 (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .start(start),
    .repeat_cnt(repeat_cnt), .abort(abort), .serial_out(so0),
    .serial_valid(sv0), .busy(busy0), .done(done0)
  );

  pattern_transmitter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2), .IDLE_LVL(IDLE_LVL)) dut2 (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .start(start),
    .repeat_cnt(repeat_cnt), .abort(abort), .serial_out(so2),
    .serial_valid(sv2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit b of a frame: pattern bits first, then the parity slot if present.
  function automatic logic frameBit(input logic [WIDTH-1:0] p, input int b);
    if (b >= WIDTH) return ^p;
    return p[b];
  endfunction

  // The whole frame as a detector would hold it after the last bit.
  function automatic logic [FL-1:0] expFrame(input logic [WIDTH-1:0] p);
    logic [FL-1:0] f;
    for (int b = 0; b < FL; b++) f[b] = frameBit(p, b);
    return f;
  endfunction

  // Expected per-cycle waveform from the cycle after start is accepted
  // until the done pulse: frames of FL valid bits, gap cycles between
  // frames, then one done cycle with busy low.
  function automatic rec_q_t buildWave(input int gap, input int frames,
                                       input logic [WIDTH-1:0] p);
    rec_q_t q;
    for (int f = 0; f < frames; f++) begin
      for (int b = 0; b < FL; b++) q.push_back('{1'b1, frameBit(p, b), 1'b1, 1'b0});
      if (f < frames - 1)
        for (int g = 0; g < gap; g++) q.push_back('{1'b0, IDLE_LVL, 1'b1, 1'b0});
    end
    q.push_back('{1'b0, IDLE_LVL, 1'b0, 1'b1});
    return q;
  endfunction

  // Advance one transmitter's model by one clock edge using the inputs
  // that were presented before the edge.
  task automatic stepOne(input int gap, inout logic [WIDTH-1:0] mp,
                         inout rec_t cur, inout rec_q_t q);
    if (reset) begin
      mp = '0;
      q.delete();
      cur = IDLE_REC;
    end else if (!cur.busy) begin
      if (load) mp = pattern;
      if (start && !abort) begin
        q = buildWave(gap, int'(repeat_cnt) + 1, mp);
        cur = q.pop_front();
      end else begin
        cur = IDLE_REC;
      end
    end else if (abort) begin
      q.delete();
      cur = IDLE_REC;
    end else begin
      cur = q.pop_front();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    num_checks++;
    if (obs !== expv) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld,
                               input logic [WIDTH-1:0] p, input logic st,
                               input logic [CNT_W-1:0] rc, input logic ab);
    reset      = r;
    load       = ld;
    pattern    = p;
    start      = st;
    repeat_cnt = rc;
    abort      = ab;
  endtask

  // One clock: update the models on the edge, then compare at the falling
  // edge. The detector registers shift serial_out into their MSB.
  task automatic step();
    @(posedge clk);
    stepOne(0, mpat0, cur0, q0);
    stepOne(2, mpat2, cur2, q2);
    cyc++;
    @(negedge clk);
    if (sv0) det0 = {so0, det0[FL-1:1]};
    if (sv2) det2 = {so2, det2[FL-1:1]};
    checkOutput($sformatf("gap0 c%0d", cyc), {28'd0, sv0, so0, busy0, done0}, {28'd0, cur0});
    checkOutput($sformatf("gap2 c%0d", cyc), {28'd0, sv2, so2, busy2, done2}, {28'd0, cur2});
    if (cur0.done) checkOutput($sformatf("gap0 frame c%0d", cyc), 32'(det0), 32'(expFrame(mpat0)));
    if (cur2.done) checkOutput($sformatf("gap2 frame c%0d", cyc), 32'(det2), 32'(expFrame(mpat2)));
  endtask

  task automatic idleFor(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, WIDTH'($urandom), 1'b0, CNT_W'($urandom), 1'b0);
      step();
    end
  endtask

  initial begin
    logic             r, ld, st, ab;
    logic [WIDTH-1:0] p;
    logic [CNT_W-1:0] rc;
    cur0 = IDLE_REC;
    cur2 = IDLE_REC;
    mpat0 = '0;
    mpat2 = '0;
    det0 = '0;
    det2 = '0;

    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    step();

    // single frame of 10110
    applyStimulus(1'b0, 1'b1, 5'b10110, 1'b0, 4'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 5'b10110, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(8);

    // load+start together, three frames
    applyStimulus(1'b0, 1'b1, 5'b00011, 1'b1, 4'd2, 1'b0);
    step();
    idleFor(24);

    // two frames
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd1, 1'b0);
    step();
    idleFor(16);

    // abort in the third bit cycle, then a clean retransmission
    applyStimulus(1'b0, 1'b1, 5'b10110, 1'b0, 4'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(2);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b1);
    step();
    idleFor(2);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(8);

    // load and start while busy are ignored
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 5'b11111, 1'b1, 4'd3, 1'b0);
    step();
    idleFor(14);

    // reset in the middle of a frame clears the pattern register
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(2);
    applyStimulus(1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b0);
    step();
    idleFor(2);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(8);

    // restart in the done cycle
    applyStimulus(1'b0, 1'b1, 5'b01101, 1'b1, 4'd0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      idleFor(1);
      if (cur0.done) break;
    end
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b0);
    step();
    idleFor(8);

    // abort beats start while idle
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 4'd0, 1'b1);
    step();
    idleFor(3);

    // all-ones repeat count
    applyStimulus(1'b0, 1'b1, 5'b11001, 1'b1, 4'hF, 1'b0);
    step();
    idleFor(120);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      rc = ($urandom_range(0, 9) == 0) ? 4'hF : CNT_W'($urandom_range(0, 3));
      p  = WIDTH'($urandom);
      applyStimulus(r, ld, p, st, rc, ab);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
